// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int MAX_DATA_RUN_DEF = 4;

  // Which requester owns the read response currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Width of a counter that must hold 0..max_run inclusive.
  function automatic int run_cnt_w(input int max_run);
    return (max_run < 2) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch, data and memory-port signals around the arbiter.
// slave = arbiter side, master = pipeline/memory environment side.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // data (load/store) port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  // single-port memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select: data beats fetch, except when data has won MAX_DATA_RUN
// contended cycles in a row, in which case fetch is forced through once.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  output logic if_win,
  output logic dm_win
);

  localparam int                CNT_W   = run_cnt_w(MAX_DATA_RUN);
  localparam logic [CNT_W-1:0]  RUN_MAX = CNT_W'(MAX_DATA_RUN);

  logic [CNT_W-1:0] run_cnt_reg;
  logic [CNT_W-1:0] run_cnt_next;
  logic             starve;

  // Pick this cycle's winner and the next contended-run count.
  always_comb begin
    starve = (run_cnt_reg == RUN_MAX);
    dm_win = ~rst & dm_req & ~(if_req & starve);
    if_win = ~rst & if_req & ~(dm_req & ~starve);
    // Only a data grant that made fetch wait extends the run; a fetch grant
    // or a cycle with no fetch pending starts it over.
    if (dm_win && if_req) begin
      run_cnt_next = starve ? run_cnt_reg : run_cnt_reg + 1'b1;
    end else begin
      run_cnt_next = '0;
    end
  end

  // Contended data-run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_reg <= '0;
    end else begin
      run_cnt_reg <= run_cnt_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Grants are combinational; read data returns to the owner one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  logic   if_win;
  logic   dm_win;
  logic   rsp_pend_reg;
  logic   rsp_pend_next;
  owner_e rsp_owner_reg;
  owner_e rsp_owner_next;

  mem_arb_pick #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .if_win (if_win),
    .dm_win (dm_win)
  );

  // Drive grants and mirror the winning request onto the memory port.
  always_comb begin
    bus.if_gnt    = if_win;
    bus.dm_gnt    = dm_win;
    bus.mem_en    = if_win | dm_win;
    bus.mem_we    = dm_win & bus.dm_we;
    bus.mem_addr  = dm_win ? bus.dm_addr : bus.if_addr;
    bus.mem_wdata = bus.dm_wdata;
  end

  // A read granted now owes a response next cycle; stores finish at the grant.
  always_comb begin
    rsp_pend_next  = if_win | (dm_win & ~bus.dm_we);
    rsp_owner_next = rsp_owner_reg;
    if (dm_win) begin
      rsp_owner_next = OWN_DM;
    end else if (if_win) begin
      rsp_owner_next = OWN_IF;
    end
  end

  // Response tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_reg  <= 1'b0;
      rsp_owner_reg <= OWN_IF;
    end else begin
      rsp_pend_reg  <= rsp_pend_next;
      rsp_owner_reg <= rsp_owner_next;
    end
  end

  // Route the returning read to its owner; nothing is returned while in reset,
  // so a read granted just before reset is dropped.
  always_comb begin
    bus.if_rvalid = rsp_pend_reg & ~rst & (rsp_owner_reg == OWN_IF);
    bus.dm_rvalid = rsp_pend_reg & ~rst & (rsp_owner_reg == OWN_DM);
    bus.if_rdata  = bus.mem_rdata;
    bus.dm_rdata  = bus.mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  localparam logic [31:0] A_IF  = 32'h10;
  localparam logic [31:0] A_ST  = 32'h20;
  localparam logic [31:0] A_DM  = 32'h30;
  localparam logic [31:0] D_IF  = 32'hDEADBEEF;
  localparam logic [31:0] D_DM  = 32'hA5A50030;
  localparam logic [31:0] D_ST  = 32'h12345678;

  // Contention table: if_req per cycle (dm_req held high) and expected dm_gnt.
  localparam logic [0:18] CON_IF = 19'b1111111111_111_0_11111;
  localparam logic [0:18] CON_DM = 19'b1111011110_111_1_11110;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] mem_arr [0:255];

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.MAX_DATA_RUN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: write at the grant edge, registered read data next cycle.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_arr[bus.mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_if_v;
    logic prev_dm_v;
    logic exp_dm;
    logic exp_if;

    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[A_IF[7:0]] = D_IF;
    mem_arr[A_DM[7:0]] = D_DM;
    bus.mem_rdata = 32'h0;

    // Reset held two edges with both requests pending.
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = A_IF;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = A_DM; bus.dm_wdata = 32'h0;
    #1;
    for (int k = 0; k < 2; k++) begin
      $display("reset cycle %0d", k);
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_dm_gnt", bus.dm_gnt, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_dm_rvalid", bus.dm_rvalid, 0);
      next_cycle();
    end

    // First cycle out of reset: data wins.
    rst = 1'b0;
    #1;
    $display("post-reset load addr %h", A_DM);
    chk("post_rst_dm_gnt", bus.dm_gnt, 1);
    chk("post_rst_if_gnt", bus.if_gnt, 0);
    chk("post_rst_mem_addr", bus.mem_addr, A_DM);
    chk("post_rst_dm_rvalid", bus.dm_rvalid, 0);
    next_cycle();

    // Fetch only; previous load returns this cycle.
    bus.dm_req = 1'b0;
    #1;
    $display("fetch addr %h", A_IF);
    chk("ld_dm_rvalid", bus.dm_rvalid, 1);
    chk("ld_dm_rdata", bus.dm_rdata, D_DM);
    chk("fo_if_gnt", bus.if_gnt, 1);
    chk("fo_dm_gnt", bus.dm_gnt, 0);
    chk("fo_mem_addr", bus.mem_addr, A_IF);
    chk("fo_mem_we", bus.mem_we, 0);
    next_cycle();

    bus.if_req = 1'b0;
    #1;
    $display("idle, fetch returns");
    chk("fo_if_rvalid", bus.if_rvalid, 1);
    chk("fo_if_rdata", bus.if_rdata, D_IF);
    chk("fo_dm_rvalid", bus.dm_rvalid, 0);
    chk("idle_mem_en", bus.mem_en, 0);
    next_cycle();

    // Contention with data loads held high.
    prev_if_v = 1'b0;
    prev_dm_v = 1'b0;
    for (int i = 0; i < 19; i++) begin
      bus.if_req = CON_IF[i];
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = A_DM;
      exp_dm = CON_DM[i];
      exp_if = CON_IF[i] & ~CON_DM[i];
      #1;
      $display("contention %0d if_req=%0d -> if_gnt=%0d dm_gnt=%0d", i, CON_IF[i], bus.if_gnt, bus.dm_gnt);
      chk($sformatf("con%0d_dm_gnt", i), bus.dm_gnt, exp_dm);
      chk($sformatf("con%0d_if_gnt", i), bus.if_gnt, exp_if);
      chk($sformatf("con%0d_mem_addr", i), bus.mem_addr, exp_dm ? A_DM : A_IF);
      chk($sformatf("con%0d_if_rvalid", i), bus.if_rvalid, prev_if_v);
      chk($sformatf("con%0d_dm_rvalid", i), bus.dm_rvalid, prev_dm_v);
      if (prev_if_v) chk($sformatf("con%0d_if_rdata", i), bus.if_rdata, D_IF);
      if (prev_dm_v) chk($sformatf("con%0d_dm_rdata", i), bus.dm_rdata, D_DM);
      prev_if_v = exp_if;
      prev_dm_v = exp_dm;
      next_cycle();
    end

    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    #1;
    $display("contention drain");
    chk("con_end_if_rvalid", bus.if_rvalid, 1);
    chk("con_end_if_rdata", bus.if_rdata, D_IF);
    chk("con_end_dm_rvalid", bus.dm_rvalid, 0);
    next_cycle();

    // Store then load to the same address.
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = A_ST; bus.dm_wdata = D_ST;
    #1;
    $display("store %h <= %h", A_ST, D_ST);
    chk("st_dm_gnt", bus.dm_gnt, 1);
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_addr", bus.mem_addr, A_ST);
    chk("st_mem_wdata", bus.mem_wdata, D_ST);
    next_cycle();

    bus.dm_we = 1'b0; bus.dm_wdata = 32'h0;
    #1;
    $display("load %h", A_ST);
    chk("st_no_rvalid", bus.dm_rvalid, 0);
    chk("ld_mem_we", bus.mem_we, 0);
    chk("ld_dm_gnt", bus.dm_gnt, 1);
    next_cycle();

    bus.dm_req = 1'b0;
    #1;
    $display("load returns");
    chk("stld_dm_rvalid", bus.dm_rvalid, 1);
    chk("stld_dm_rdata", bus.dm_rdata, D_ST);
    chk("stld_if_rvalid", bus.if_rvalid, 0);
    next_cycle();

    // Back-to-back fetch then load.
    bus.if_req = 1'b1; bus.if_addr = A_IF;
    #1;
    $display("alt fetch %h", A_IF);
    chk("alt_if_gnt", bus.if_gnt, 1);
    next_cycle();

    bus.if_req = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = A_DM;
    #1;
    $display("alt load %h", A_DM);
    chk("alt_dm_gnt", bus.dm_gnt, 1);
    chk("alt_if_rvalid", bus.if_rvalid, 1);
    chk("alt_if_rdata", bus.if_rdata, D_IF);
    chk("alt_dm_rvalid0", bus.dm_rvalid, 0);
    next_cycle();

    bus.dm_req = 1'b0;
    #1;
    $display("alt load returns");
    chk("alt_dm_rvalid1", bus.dm_rvalid, 1);
    chk("alt_dm_rdata", bus.dm_rdata, D_DM);
    chk("alt_if_rvalid1", bus.if_rvalid, 0);
    next_cycle();

    // Reset while a load response is due.
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = A_DM;
    #1;
    $display("load before reset");
    chk("rmid_dm_gnt", bus.dm_gnt, 1);
    next_cycle();

    rst = 1'b1;
    bus.dm_req = 1'b0;
    #1;
    $display("reset mid-read");
    chk("rmid_rvalid_n1", bus.dm_rvalid, 0);
    next_cycle();

    rst = 1'b0;
    #1;
    $display("after reset idle");
    chk("rmid_rvalid_n2", bus.dm_rvalid, 0);
    chk("rmid_if_rvalid_n2", bus.if_rvalid, 0);
    next_cycle();
    chk("rmid_rvalid_n3", bus.dm_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port instruction/data memory between the instruction-fetch stage and the load/store stage of the CPU. Each cycle it grants at most one requester, drives the memory port, and returns read data to the owner one cycle later. Data accesses have priority over fetches, with a starvation guard so fetch always progresses. It sits between the pipeline front/back ends and the memory array.

## Interface

- ADDR_W, 32, address width (word address)
- DATA_W, 32, data width
- MAX_DATA_RUN, 4, max consecutive contended data grants before fetch is forced a grant (>=1)

Ports:

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  dm_rdata valid (loads only, registered)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read mem_en

## Operation

- One access per cycle, fully pipelined; new grant possible every cycle, including the cycle a previous read returns.
- Pick rule per cycle:
  - only dm_req: grant data; only if_req: grant fetch; neither: mem_en=0.
  - both: grant data unless run_cnt == MAX_DATA_RUN, then grant fetch.
- run_cnt (0..MAX_DATA_RUN): +1 on a data grant while if_req=1 (contended); cleared on any fetch grant or any cycle with if_req=0; never exceeds MAX_DATA_RUN.
- Memory port mirrors the granted request: mem_en=1, mem_addr from winner, mem_we = dm_we if data wins else 0, mem_wdata = dm_wdata.
- Response tracking: register rsp_pend (read granted last cycle) and rsp_owner (IF/DM). Stores set rsp_pend=0; they complete at the grant edge with no response.
- if_rvalid = rsp_pend & owner==IF; dm_rvalid = rsp_pend & owner==DM. Both rdata outputs pass mem_rdata; content is don't-care when rvalid=0.
- Store at cycle N then load to the same address granted at N+1 returns the stored data.

## Timing

- Reset (synchronous, rst high at an edge): rsp_pend=0, rsp_owner=IF, run_cnt=0. While rst=1: if_gnt=dm_gnt=0, mem_en=mem_we=0, if_rvalid=dm_rvalid=0.
- Reset mid-operation: a read granted the cycle before reset produces no rvalid; no grant during reset.
- Grant latency 0 cycles (same cycle as req when it wins); read latency 1 cycle from grant to rvalid.
- if_rvalid and dm_rvalid never both 1; at most one of if_gnt/dm_gnt per cycle.
- Dropping req before gnt is a protocol violation; behaviour unspecified.

## Structure

- Package mem_arb_pkg: owner enum (OWN_IF, OWN_DM), default ADDR_W/DATA_W constants.
- One sub-module mem_arb_pick: combinational winner select plus run_cnt register and saturation; top holds response tracking and port muxing.

## Test plan

- Reset: rst=1 for 2 cycles with both reqs high -> no gnt, mem_en=0, rvalids 0; first cycle after rst low -> dm_gnt=1.
- Fetch only: if_req, addr 0x10, memory holds 0xDEADBEEF -> if_gnt same cycle, if_rvalid=1 and if_rdata=0xDEADBEEF next cycle, dm_rvalid=0.
- Contention, MAX_DATA_RUN=4: both req held continuously (dm loads) -> grant sequence DM,DM,DM,DM,IF,DM,DM,DM,DM,IF; run_cnt never >4.
- Store then load: dm store 0x20 <= 0x12345678 at cycle N, dm load 0x20 at N+1 -> dm_rvalid at N+2 with 0x12345678; no dm_rvalid at N+1.
- Back-to-back alternating: fetch read at N, load at N+1 -> if_rvalid at N+1 only, dm_rvalid at N+2 only, correct data each.
- Reset mid-read: load granted at N, rst=1 at N+1 edge -> no dm_rvalid at N+1 or after until a new grant.
